// File: rtl/i2c_arb_pkg.sv
// Shared constants for the I2C command arbiter: FSM state encoding,
// the data byte width and the byte returned when a transaction times out.
package i2c_arb_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_END   = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  localparam logic [BYTE_W-1:0] TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the first set req bit at or
// above ptr wins, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx,
  output logic            any_req
);

  // Scan offsets from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any_req = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt_idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
    gnt_oh[gnt_idx] = any_req;
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master between NREQ
// requesters. Optional busy watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BYTE_W-1:0] req_addr,
  input  logic [NREQ*BYTE_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_rw,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [BYTE_W-1:0]      rd_data,
  output logic [BYTE_W-1:0]      m_addr,
  output logic [BYTE_W-1:0]      m_data,
  output logic                   m_rw,
  output logic                   m_new_cmd,
  input  logic                   m_busy,
  input  logic [BYTE_W-1:0]      m_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [BYTE_W-1:0] rd_data_q, rd_data_d;
  logic [BYTE_W-1:0] m_addr_q, m_addr_d;
  logic [BYTE_W-1:0] m_data_q, m_data_d;
  logic              m_rw_q, m_rw_d;
  logic              m_new_cmd_q, m_new_cmd_d;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        err_q, err_d;
`endif

  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [BYTE_W-1:0] addr_arr [NREQ];
  logic [BYTE_W-1:0] data_arr [NREQ];

  // Unpack the flattened per-requester byte buses.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*BYTE_W +: BYTE_W];
    assign data_arr[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Next-state logic for the grant/issue/wait/complete sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rd_data_d   = rd_data_q;
    m_addr_d    = m_addr_q;
    m_data_d    = m_data_q;
    m_rw_d      = m_rw_q;
    m_new_cmd_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    to_d  = to_q;
    err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d       = arb_oh;
          idx_d       = arb_idx;
          m_addr_d    = addr_arr[arb_idx];
          m_data_d    = data_arr[arb_idx];
          m_rw_d      = req_rw[arb_idx];
          m_new_cmd_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_START;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d = '0;
        to_d  = 1'b0;
`endif
      end
      ST_WAIT_START, ST_WAIT_END: begin
        if (state_q == ST_WAIT_START && m_busy) state_d = ST_WAIT_END;
        if (state_q == ST_WAIT_END && !m_busy)  state_d = ST_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
        // The watchdog overrides any concurrent busy transition.
        cnt_d = cnt_q + 16'd1;
        if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
        err_d = to_q;
        if (to_q) rd_data_d = TIMEOUT_BYTE;
        else if (m_rw_q) rd_data_d = m_rdata;
`else
        if (m_rw_q) rd_data_d = m_rdata;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rd_data_q   <= '0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
      m_rw_q      <= 1'b0;
      m_new_cmd_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q <= '0;
      to_q  <= 1'b0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      m_addr_q    <= m_addr_d;
      m_data_q    <= m_data_d;
      m_rw_q      <= m_rw_d;
      m_new_cmd_q <= m_new_cmd_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      to_q  <= to_d;
      err_q <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign m_addr    = m_addr_q;
  assign m_data    = m_data_q;
  assign m_rw      = m_rw_q;
  assign m_new_cmd = m_new_cmd_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter (NREQ=3) with a behavioural
// I2C master model and a round-robin reference model.
module tb_i2c_cmd_arbiter;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_addr = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_rw = '0;
  logic [2:0]  gnt, done;
  logic        err;
  logic [7:0]  rd_data, m_addr, m_data;
  logic        m_rw, m_new_cmd;
  logic        m_busy = 1'b0;
  logic [7:0]  m_rdata = 8'h00;

  int          busy_len = 4;
  logic [7:0]  slave_byte = 8'h00;
  bit          stuck = 1'b0;
  int          bcnt = 0;

  int          total = 0;
  int          bad = 0;
  int          ptr_m = 0;
  logic [7:0]  rd_exp = 8'h00;

  typedef struct {
    logic [2:0] gnt;
    logic [7:0] addr;
    logic [7:0] data;
    logic       rw;
    int         ncmd;
    int         lat;
    bit         gnt_bad;
    logic [2:0] done;
    logic [7:0] rd;
    logic       err;
    logic [2:0] gnt_at_done;
    logic [2:0] done_next;
    bit         tmo;
  } obs_t;

  i2c_cmd_arbiter #(.NREQ(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .res_n(res_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
    .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_new_cmd(m_new_cmd),
    .m_busy(m_busy), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // I2C master model: busy rises the cycle after new_cmd and lasts busy_len cycles.
  always @(posedge clk) begin
    if (!res_n) begin
      m_busy <= 1'b0;
      bcnt   <= 0;
    end else if (m_new_cmd) begin
      m_busy <= 1'b1;
      bcnt   <= busy_len;
    end else if (m_busy && !stuck) begin
      if (bcnt <= 1) begin
        m_busy  <= 1'b0;
        m_rdata <= slave_byte;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  // Reference arbitration: first requesting index at or after ptr, wrapping.
  function automatic int pick(logic [2:0] r, int p);
    for (int k = 0; k < 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] oh(int w);
    logic [2:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  // Follows one transaction from grant to one cycle after done.
  task automatic observe(output obs_t o, input logic [2:0] drop_at_busy, input int clr_mode);
    int n;
    int busy_seen;
    o.gnt = 'x; o.addr = 'x; o.data = 'x; o.rw = 'x; o.done = 'x; o.rd = 'x;
    o.err = 'x; o.gnt_at_done = 'x; o.done_next = 'x;
    o.ncmd = 0; o.lat = 0; o.gnt_bad = 0; o.tmo = 0;
    busy_seen = 0;
    while (gnt === 3'b000 && o.lat < 50) begin
      @(negedge clk);
      o.lat++;
    end
    if (gnt === 3'b000) begin
      o.tmo = 1;
      return;
    end
    o.gnt = gnt; o.addr = m_addr; o.data = m_data; o.rw = m_rw;
    o.ncmd = m_new_cmd ? 1 : 0;
    if (!$onehot(gnt)) o.gnt_bad = 1;
    n = 0;
    while (done === 3'b000 && n < 1000) begin
      @(negedge clk);
      n++;
      if (m_new_cmd) o.ncmd++;
      if (done === 3'b000 && gnt !== o.gnt) o.gnt_bad = 1;
      if (m_addr !== o.addr || m_data !== o.data || m_rw !== o.rw) o.gnt_bad = 1;
      if (m_busy) busy_seen++;
      if (busy_seen == 2) req = req & ~drop_at_busy;
    end
    if (done === 3'b000) begin
      o.tmo = 1;
      return;
    end
    o.done = done; o.rd = rd_data; o.err = err; o.gnt_at_done = gnt;
    if (clr_mode == 1) req = req & ~done;
    else if (clr_mode == 2) req = '0;
    @(negedge clk);
    o.done_next = done;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (gnt !== 3'b000 || done !== 3'b000) begin bad++; $display("FAIL reset_gnt_done got=%b/%b exp=000/000", gnt, done); end
    total++; if ({m_addr, m_data, m_rw, m_new_cmd} !== 18'h0) begin bad++; $display("FAIL reset_master got=%h/%h/%b/%b exp=0", m_addr, m_data, m_rw, m_new_cmd); end
    total++; if (rd_data !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL reset_rd_err got=%h/%b exp=00/0", rd_data, err); end
    res_n = 1'b1;
    ptr_m = 0; rd_exp = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int w;
    req_addr = {8'h22, 8'h21, 8'h20};
    req_data = {8'h12, 8'h11, 8'h10};
    req_rw = 3'b010;
    slave_byte = 8'h5A;
    busy_len = 3;
    @(negedge clk);
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      w = pick(req, ptr_m);
      observe(o, 3'b000, (t == 3) ? 2 : 0);
      total++; if (o.tmo || o.gnt !== oh(w)) begin bad++; $display("FAIL b2b_gnt t=%0d got=%b exp=%b", t, o.gnt, oh(w)); end
      total++; if (o.done !== oh(w) || o.done_next !== 3'b000) begin bad++; $display("FAIL b2b_done t=%0d got=%b,%b exp=%b,000", t, o.done, o.done_next, oh(w)); end
      total++; if (o.ncmd != 1 || o.gnt_bad) begin bad++; $display("FAIL b2b_cmd t=%0d ncmd=%0d gnt_bad=%0d exp 1/0", t, o.ncmd, o.gnt_bad); end
      if (t > 0) begin
        total++; if (o.lat != 0) begin bad++; $display("FAIL b2b_gap t=%0d got=%0d exp=0", t, o.lat); end
      end
      if (req_rw[w]) rd_exp = slave_byte;
      total++; if (o.rd !== rd_exp || o.gnt_at_done !== 3'b000) begin bad++; $display("FAIL b2b_rd t=%0d got=%h gnt=%b exp=%h gnt=000", t, o.rd, o.gnt_at_done, rd_exp); end
      ptr_m = (w + 1) % 3;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    obs_t o;
    req_addr[15:8] = 8'h50;
    req_data[15:8] = 8'hA5;
    req_rw = 3'b000;
    busy_len = 20;
    slave_byte = 8'hC3;
    @(negedge clk);
    req = 3'b010;
    observe(o, 3'b000, 2);
    total++; if (o.tmo || o.gnt !== 3'b010 || o.lat != 1) begin bad++; $display("FAIL wr_gnt got=%b lat=%0d exp=010 lat=1", o.gnt, o.lat); end
    total++; if (o.addr !== 8'h50 || o.data !== 8'hA5 || o.rw !== 1'b0) begin bad++; $display("FAIL wr_master got=%h/%h/%b exp=50/a5/0", o.addr, o.data, o.rw); end
    total++; if (o.ncmd != 1) begin bad++; $display("FAIL wr_newcmd got=%0d exp=1", o.ncmd); end
    total++; if (o.done !== 3'b010 || o.done_next !== 3'b000) begin bad++; $display("FAIL wr_done got=%b,%b exp=010,000", o.done, o.done_next); end
    total++; if (o.rd !== rd_exp || o.err !== 1'b0) begin bad++; $display("FAIL wr_rd_err got=%h/%b exp=%h/0", o.rd, o.err, rd_exp); end
    ptr_m = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop();
    obs_t o;
    int w;
    int w2;
    req_addr = {8'hA2, 8'hA1, 8'hA0};
    req_data = {8'hB2, 8'hB1, 8'hB0};
    req_rw = 3'b000;
    busy_len = 6;
    @(negedge clk);
    req = 3'b111;
    w = pick(req, ptr_m);
    observe(o, 3'b100, 0);
    total++; if (o.tmo || o.gnt !== oh(w) || o.done !== oh(w)) begin bad++; $display("FAIL drop_done got=%b/%b exp=%b", o.gnt, o.done, oh(w)); end
    ptr_m = (w + 1) % 3;
    w2 = pick(req, ptr_m);
    observe(o, 3'b000, 2);
    total++; if (o.tmo || o.gnt !== oh(w2) || o.lat != 0) begin bad++; $display("FAIL drop_next got=%b lat=%0d exp=%b lat=0", o.gnt, o.lat, oh(w2)); end
    total++; if (o.addr !== req_addr[w2*8 +: 8]) begin bad++; $display("FAIL drop_addr got=%h exp=%h", o.addr, req_addr[w2*8 +: 8]); end
    ptr_m = (w2 + 1) % 3;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    obs_t o;
    req_addr[7:0] = 8'h91;
    req_rw[0] = 1'b1;
    slave_byte = 8'h3C;
    busy_len = 5;
    @(negedge clk);
    req = 3'b001;
    observe(o, 3'b000, 2);
    total++; if (o.tmo || o.done !== 3'b001 || o.rw !== 1'b1) begin bad++; $display("FAIL rd_done got=%b rw=%b exp=001 rw=1", o.done, o.rw); end
    total++; if (o.rd !== 8'h3C || o.err !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b exp=3c/0", o.rd, o.err); end
    rd_exp = 8'h3C;
    ptr_m = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    int w;
    for (int it = 0; it < 12; it++) begin
      req_addr = 24'($urandom);
      req_data = 24'($urandom);
      req_rw = 3'($urandom);
      busy_len = $urandom_range(6, 1);
      slave_byte = 8'($urandom);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      @(negedge clk);
      req = 3'($urandom_range(7, 1));
      w = pick(req, ptr_m);
      observe(o, 3'b000, 2);
      total++; if (o.tmo || o.gnt !== oh(w) || o.gnt_bad) begin bad++; $display("FAIL rnd_gnt it=%0d got=%b exp=%b", it, o.gnt, oh(w)); end
      total++; if (o.addr !== req_addr[w*8 +: 8] || o.data !== req_data[w*8 +: 8] || o.rw !== req_rw[w]) begin bad++; $display("FAIL rnd_master it=%0d got=%h/%h/%b exp=%h/%h/%b", it, o.addr, o.data, o.rw, req_addr[w*8 +: 8], req_data[w*8 +: 8], req_rw[w]); end
      if (req_rw[w]) rd_exp = slave_byte;
      total++; if (o.done !== oh(w) || o.rd !== rd_exp || o.err !== 1'b0 || o.ncmd != 1) begin bad++; $display("FAIL rnd_done it=%0d got=%b/%h/%b/%0d exp=%b/%h/0/1", it, o.done, o.rd, o.err, o.ncmd, oh(w), rd_exp); end
      ptr_m = (w + 1) % 3;
    end
  endtask

  task automatic test_midreset();
    obs_t o;
    int n;
    int busy_seen;
    int done_seen;
    req_addr = {8'h72, 8'h71, 8'h70};
    req_data = {8'h62, 8'h61, 8'h60};
    req_rw = 3'b000;
    busy_len = 10;
    @(negedge clk);
    req = 3'b001;
    n = 0; busy_seen = 0; done_seen = 0;
    while (busy_seen < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (m_busy) busy_seen++;
    end
    total++; if (busy_seen < 2 || gnt === 3'b000) begin bad++; $display("FAIL mrst_reach busy=%0d gnt=%b exp busy>=2 gnt!=0", busy_seen, gnt); end
    #2 res_n = 1'b0;
    #1;
    total++; if ({gnt, done, err, rd_data, m_addr, m_data, m_rw, m_new_cmd} !== 33'h0) begin bad++; $display("FAIL mrst_async got=%b/%b/%b/%h/%h/%h/%b/%b exp=0", gnt, done, err, rd_data, m_addr, m_data, m_rw, m_new_cmd); end
    req = 3'b110;
    repeat (2) begin
      @(negedge clk);
      if (done !== 3'b000) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL mrst_nodone got=%0d exp=0", done_seen); end
    res_n = 1'b1;
    ptr_m = 0; rd_exp = 8'h00;
    observe(o, 3'b000, 2);
    total++; if (o.tmo || o.gnt !== oh(pick(3'b110, 0))) begin bad++; $display("FAIL mrst_gnt got=%b exp=%b", o.gnt, oh(pick(3'b110, 0))); end
    ptr_m = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stuck();
`ifdef I2C_ARB_TIMEOUT_EN
    obs_t o;
    int n;
    req_rw = 3'b001;
    slave_byte = 8'h44;
    busy_len = 2;
    stuck = 1'b1;
    @(negedge clk);
    req = 3'b001;
    observe(o, 3'b000, 2);
    total++; if (o.tmo || o.done !== 3'b001 || o.err !== 1'b1) begin bad++; $display("FAIL to_done got=%b/%b exp=001/1", o.done, o.err); end
    total++; if (o.rd !== 8'hFF) begin bad++; $display("FAIL to_rd got=%h exp=ff", o.rd); end
    stuck = 1'b0;
    n = 0;
    while (m_busy && n < 20) begin @(negedge clk); n++; end
`else
    int n;
    int done_seen;
    req_rw = 3'b000;
    stuck = 1'b1;
    @(negedge clk);
    req = 3'b001;
    n = 0;
    while (gnt === 3'b000 && n < 20) begin @(negedge clk); n++; end
    done_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done !== 3'b000) done_seen++;
    end
    total++; if (done_seen != 0 || gnt !== oh(pick(3'b001, ptr_m))) begin bad++; $display("FAIL stuck_wait done=%0d gnt=%b exp 0/%b", done_seen, gnt, oh(pick(3'b001, ptr_m))); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL stuck_err got=%b exp=0", err); end
    req = 3'b000;
    res_n = 1'b0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_write();
    test_drop();
    test_read();
    test_random();
    test_midreset();
    test_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
